// File: rtl/eth_hdr_pkg.sv
// Shared types and constants for the Ethernet/IPv4 header parser.
// Holds the descriptor layout, header word indices and classification defaults.
package eth_hdr_pkg;

  localparam int HDR_WORDS = 9;

  // Index of the 32-bit frame word that carries each header field
  localparam int W_DST_HI  = 0;
  localparam int W_MAC_MIX = 1;
  localparam int W_SRC_LO  = 2;
  localparam int W_ETYPE   = 3;
  localparam int W_PROTO   = 5;
  localparam int W_SIP_HI  = 6;
  localparam int W_IP_MIX  = 7;
  localparam int W_DIP_LO  = 8;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_TCP  = 8'h06;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] etype;
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic        is_ipv4_tcp;
    logic        runt;
  } hdr_t;

  // Stamp the runt flag and the IPv4/TCP classification onto captured fields
  function automatic hdr_t hdr_finalize(input hdr_t h, input logic runt,
                                        input logic [15:0] etype_match,
                                        input logic [7:0] proto_match);
    hdr_t r;
    r             = h;
    r.runt        = runt;
    r.is_ipv4_tcp = (h.etype == etype_match) & (h.proto == proto_match) & ~runt;
    return r;
  endfunction

endpackage

// File: rtl/eth_hdr_parser.sv
// Extracts MAC/EtherType/IPv4 fields from the first nine words of each frame.
// Optional saturating frame statistics are enabled by defining HDR_PARSER_STATS_EN.
module eth_hdr_parser
  import eth_hdr_pkg::*;
#(
  parameter logic [15:0] IPV4_ETYPE = ETYPE_IPV4,
  parameter logic [7:0]  TCP_PROTO  = PROTO_TCP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_rxd_tdata,
  input  logic        i_rxd_tvalid,
  input  logic        i_rxd_tlast,
  output logic        i_rxd_tready,
  output hdr_t        o_hdr,
  output logic        o_hdr_valid,
  input  logic        i_hdr_ready
`ifdef HDR_PARSER_STATS_EN
  ,
  output logic [15:0] o_cnt_frames,
  output logic [15:0] o_cnt_ipv4_tcp,
  output logic [15:0] o_cnt_runt
`endif
);

  localparam logic [0:0] ST_HDR     = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;
  localparam logic [3:0] LAST_IDX   = 4'(HDR_WORDS - 1);

  logic [0:0] r_state;
  logic [3:0] r_cnt;
  hdr_t       r_cap;
  hdr_t       r_hdr;
  logic       r_hdr_valid;

  logic w_tready;
  logic w_hdr_beat;
  logic w_last_hdr;
  logic w_publish;
  hdr_t w_cap_base;
  hdr_t w_cap_next;
  hdr_t w_pub_hdr;

  // Header beats stall only while an unaccepted descriptor is held
  assign w_tready   = (r_state == ST_PAYLOAD) | ~(r_hdr_valid & ~i_hdr_ready);
  assign w_hdr_beat = i_rxd_tvalid & w_tready & (r_state == ST_HDR);
  assign w_last_hdr = (r_cnt == LAST_IDX);
  assign w_publish  = w_hdr_beat & (i_rxd_tlast | w_last_hdr);

  // Beat 0 starts from a clean slate so a runt reports unreceived fields as zero
  assign w_cap_base = (r_cnt == 4'd0) ? '0 : r_cap;

  always_comb begin
    w_cap_next = w_cap_base;
    case (r_cnt)
      4'(W_DST_HI): w_cap_next.dst_mac[47:16] = i_rxd_tdata;
      4'(W_MAC_MIX): begin
        w_cap_next.dst_mac[15:0]  = i_rxd_tdata[31:16];
        w_cap_next.src_mac[47:32] = i_rxd_tdata[15:0];
      end
      4'(W_SRC_LO): w_cap_next.src_mac[31:0] = i_rxd_tdata;
      4'(W_ETYPE):  w_cap_next.etype         = i_rxd_tdata[31:16];
      4'(W_PROTO):  w_cap_next.proto         = i_rxd_tdata[7:0];
      4'(W_SIP_HI): w_cap_next.src_ip[31:16] = i_rxd_tdata[15:0];
      4'(W_IP_MIX): begin
        w_cap_next.src_ip[15:0]  = i_rxd_tdata[31:16];
        w_cap_next.dst_ip[31:16] = i_rxd_tdata[15:0];
      end
      4'(W_DIP_LO): w_cap_next.dst_ip[15:0] = i_rxd_tdata[31:16];
      default: ;
    endcase
  end

  assign w_pub_hdr = hdr_finalize(w_cap_next, ~w_last_hdr, IPV4_ETYPE, TCP_PROTO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HDR;
      r_cnt       <= 4'd0;
      r_cap       <= '0;
      r_hdr       <= '0;
      r_hdr_valid <= 1'b0;
    end else begin
      if (w_hdr_beat) begin
        r_cap <= w_cap_next;
        if (w_publish) begin
          r_cnt   <= 4'd0;
          r_state <= i_rxd_tlast ? ST_HDR : ST_PAYLOAD;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else if ((r_state == ST_PAYLOAD) & i_rxd_tvalid & i_rxd_tlast) begin
        r_state <= ST_HDR;
      end

      // A publish in the same cycle as an accept keeps valid high with new contents
      if (w_publish) begin
        r_hdr       <= w_pub_hdr;
        r_hdr_valid <= 1'b1;
      end else if (r_hdr_valid & i_hdr_ready) begin
        r_hdr_valid <= 1'b0;
      end
    end
  end

  assign i_rxd_tready = w_tready;
  assign o_hdr        = r_hdr;
  assign o_hdr_valid  = r_hdr_valid;

`ifdef HDR_PARSER_STATS_EN
  logic [15:0] r_cnt_frames;
  logic [15:0] r_cnt_ipv4_tcp;
  logic [15:0] r_cnt_runt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_frames   <= 16'd0;
      r_cnt_ipv4_tcp <= 16'd0;
      r_cnt_runt     <= 16'd0;
    end else if (w_publish) begin
      if (r_cnt_frames != 16'hFFFF) r_cnt_frames <= r_cnt_frames + 16'd1;
      if (w_pub_hdr.is_ipv4_tcp && (r_cnt_ipv4_tcp != 16'hFFFF))
        r_cnt_ipv4_tcp <= r_cnt_ipv4_tcp + 16'd1;
      if (w_pub_hdr.runt && (r_cnt_runt != 16'hFFFF)) r_cnt_runt <= r_cnt_runt + 16'd1;
    end
  end

  assign o_cnt_frames   = r_cnt_frames;
  assign o_cnt_ipv4_tcp = r_cnt_ipv4_tcp;
  assign o_cnt_runt     = r_cnt_runt;
`endif

endmodule
